decode_stage: RTL
=================

# decode_stage

Registered, parametrised RV32I instruction decode stage with valid/ready handshaking on both sides. It sits between fetch and register-read. Beyond field slicing, it:
- generates sign-extended immediates for every format;
- classifies the instruction format and flags illegal encodings;
- supports flush;
- sustains one instruction per cycle under back-pressure through a 2-entry skid buffer.

## Interface
- `XLEN`, 32: immediate output width; immediates sign-extend from bit 31 to `XLEN`. Legal values: 32, 64.
- `EN_M`, 0: when 1, OP with fn7=`0000001` is legal (M extension). When 0 it is illegal.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; drops all buffered and incoming instructions.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts; purely registered (no combinational path from `out_ready`).
- `instIn` in 32: raw instruction.
- `pcIn` in `XLEN`: instruction PC.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts.
- `instOut` out 32: raw instruction passthrough.
- `pcOut` out `XLEN`: PC passthrough.
- `opcode` out 7, `rd` out 5, `rs1` out 5, `rs2` out 5, `fn3` out 3, `fn7` out 7: fixed RV bit slices.
- `imm` out `XLEN`: format-selected sign-extended immediate; 0 for R-format and for illegal encodings.
- `fmt` out 3: `fmt_t` (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL).
- `illegal` out 1: set when `fmt` = FMT_ILL.

## Operation
- Decode is combinational on the accepted word. The result is captured in the output register, together with `instOut` and `pcOut`.
- Opcode map:
  - OP → R.
  - OP-IMM, LOAD, JALR, SYSTEM → I.
  - STORE → S.
  - BRANCH → B.
  - LUI, AUIPC → U.
  - JAL → J.
  - Anything else, or `instIn[1:0]` ≠ `11` → ILL.
- Illegal checks beyond the opcode:
  - BRANCH with fn3 ∈ {2, 3}.
  - LOAD with fn3 ∈ {3, 6, 7}.
  - STORE with fn3 > 2.
  - JALR with fn3 ≠ 0.
  - OP with fn7 ∉ {`0000000`, `0100000`}, except `0000001` when `EN_M` = 1.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All formats sign-extend from inst[31] to `XLEN`.
- Field slices are always driven from the captured word, whatever the format.
- Storage: main register plus one skid register.
  - States: EMPTY (main invalid), ONE (main valid), TWO (main and skid valid).
  - `in_ready` = (state ≠ TWO), registered.
  - EMPTY: accept → ONE.
  - ONE: accept and `out_ready` → ONE (main replaced). Accept only → TWO (new word to skid). `out_ready` only → EMPTY.
  - TWO: `out_ready` → ONE (skid moves to main). No accept is possible.
- `flush` has priority over every transition. State → EMPTY and the `in_valid` word that cycle is discarded. Outputs other than `out_valid` hold their last values.

## Timing
- Latency 1: a word accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput is 1 per cycle while `out_ready` = 1. A single stall cycle is absorbed by the skid buffer without a bubble.
- A transfer happens on an edge where valid && ready. The bundle must stay stable while `out_valid` && !`out_ready`.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, state EMPTY.
  - All data outputs 0, `fmt` = FMT_R, `illegal` = 0.
- Reset asserted mid-operation discards both entries immediately and asynchronously.
- `in_ready` deasserts on the edge that fills the skid. It reasserts on the edge that drains it.

## Structure
- Package `decode_pkg`:
  - `fmt_t` enum.
  - 7-bit opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
  - Packed `dec_bundle_t` (inst, pc, fields, imm, fmt).
- One sub-module: `imm_gen`, a combinational unit taking inst and `fmt` and returning the `XLEN` immediate. It is reused later by the branch unit.
- The skid/handshake logic stays in `decode_stage`.

## Test plan
- Streaming with `out_ready` = 1 and `XLEN` = 32. Each word below is accepted on consecutive edges and appears one cycle later:
  - `00848933` → R: rd 18, rs1 9, rs2 8, fn3 0, fn7 0, imm 0.
  - `10100493` → I: rd 9, imm 257.
  - `0082a223` → S: rs1 5, rs2 8, fn3 2, imm 4.
  - `014c6463` → B: fn3 6, rs1 24, rs2 20, imm 8.
  - `7ff080e7` → I (JALR): rd 1, imm 2047.
  - `0000006f` → J: imm 0.
  - `10000917` → U: rd 18, imm `10000000`.
- With `XLEN` = 64: `872370b7` → U, rd 1, imm `FFFFFFFF87237000`.
- Illegal encodings:
  - `00000000` → `illegal` = 1, imm 0.
  - `02848933` → `illegal` = 1 with `EN_M` = 0; legal R with `EN_M` = 1.
  - `0082b223` (STORE fn3 3) → illegal.
- Back-pressure: hold `out_ready` = 0 for 3 cycles while `in_valid` = 1.
  - Exactly 2 words are accepted, then `in_ready` = 0.
  - On release, order is preserved and there is no bubble or duplicate.
- Flush in state TWO with `in_valid` = 1: the next cycle has `out_valid` = 0, `in_ready` = 1, and the offered word is dropped.
- Assert `rst_n` low mid-stream, asynchronously between edges: `out_valid` drops immediately and `in_ready` = 1. After release, the first accepted word decodes correctly.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared RV32I decode types, opcode constants and format classifier
// Bundle carries pc/imm at the widest XLEN so one type serves both configurations.
package decode_pkg;

   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_t;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [31:0]         inst;
      logic [XLEN_MAX-1:0] pc;
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          fn3;
      logic [6:0]          fn7;
      logic [XLEN_MAX-1:0] imm;
      fmt_t                fmt;
   } dec_bundle_t;

   function automatic fmt_t classify(input logic [31:0] inst, input logic en_m);
      fmt_t       f;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = inst[14:12];
      f7 = inst[31:25];
      f  = FMT_ILL;
      case (inst[6:0])
         OP:             if (f7 == 7'b0000000 || f7 == 7'b0100000 ||
                             (en_m && f7 == 7'b0000001)) f = FMT_R;
         OP_IMM, SYSTEM: f = FMT_I;
         LOAD:           if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) f = FMT_I;
         JALR:           if (f3 == 3'd0) f = FMT_I;
         STORE:          if (f3 <= 3'd2) f = FMT_S;
         BRANCH:         if (f3 != 3'd2 && f3 != 3'd3) f = FMT_B;
         LUI, AUIPC:     f = FMT_U;
         JAL:            f = FMT_J;
         default:        f = FMT_ILL;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// rtl/decode_imm_gen.sv - combinational format-selected sign-extended immediate
// Shared with the branch unit; R and illegal formats yield zero.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  fmt_t            fmt,
   output logic [XLEN-1:0] imm
);

   logic [63:0] imm_full;

   always_comb begin
      imm_full = '0;
      case (fmt)
         FMT_I:   imm_full = {{52{inst[31]}}, inst[31:20]};
         FMT_S:   imm_full = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm_full = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm_full = {{32{inst[31]}}, inst[31:12], 12'b0};
         FMT_J:   imm_full = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm_full = '0;
      endcase
   end

   assign imm = imm_full[XLEN-1:0];

   logic unused_opc;
   assign unused_opc = ^inst[6:0];

   if (XLEN < 64) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^imm_full[63:XLEN];
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with 2-entry skid buffer
// in_ready is a flop so fetch never sees a combinational path from out_ready.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instIn,
   input  logic [XLEN-1:0] pcIn,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     instOut,
   output logic [XLEN-1:0] pcOut,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      fn3,
   output logic [6:0]      fn7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   dec_bundle_t     main_q, main_d;
   dec_bundle_t     skid_q, skid_d;
   dec_bundle_t     dec;
   fmt_t            dec_fmt;
   logic [XLEN-1:0] dec_imm;
   logic            accept;

   assign dec_fmt = classify(instIn, EN_M);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst (instIn),
      .fmt  (dec_fmt),
      .imm  (dec_imm)
   );

   always_comb begin
      dec        = '0;
      dec.inst   = instIn;
      dec.pc     = 64'(pcIn);
      dec.opcode = instIn[6:0];
      dec.rd     = instIn[11:7];
      dec.fn3    = instIn[14:12];
      dec.rs1    = instIn[19:15];
      dec.rs2    = instIn[24:20];
      dec.fn7    = instIn[31:25];
      dec.imm    = 64'(dec_imm);
      dec.fmt    = dec_fmt;
   end

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = dec;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  main_d = dec;
               end else if (accept) begin
                  skid_d  = dec;
                  state_d = TWO;
               end else if (out_ready) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign instOut   = main_q.inst;
   assign pcOut     = main_q.pc[XLEN-1:0];
   assign opcode    = main_q.opcode;
   assign rd        = main_q.rd;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign fn3       = main_q.fn3;
   assign fn7       = main_q.fn7;
   assign imm       = main_q.imm[XLEN-1:0];
   assign fmt       = main_q.fmt;
   assign illegal   = (main_q.fmt == FMT_ILL);

   if (XLEN < 64) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^{main_q.pc[63:XLEN], main_q.imm[63:XLEN]};
   end

endmodule
